// File: rtl/clk_cpu_pkg.sv
// Shared definitions for the CPU clock-enable controller: state/mode codes
// and the legality check on the Clk_CPU pulse width.
package clk_cpu_pkg;

    // State codes double as the externally visible mode field.
    typedef enum logic [1:0] {
        ST_HALT   = 2'b00,
        ST_FAST   = 2'b01,
        ST_SLOW   = 2'b10,
        ST_SWITCH = 2'b11
    } state_t;

    // Clk_CPU must drop again before the next fast tick can arrive.
    function automatic bit pw_in_range(input int fast_bit, input int pw);
        return (pw >= 1) && (pw < (1 << (fast_bit + 1)) - 1);
    endfunction

endpackage

// File: rtl/clk_cpu_ctrl_debounce.sv
// Switch/button conditioner: 2-FF synchronizer followed by a stability
// counter. The output flips only after DB_CYCLES consecutive synchronized
// samples that disagree with it, giving a latency of 2+DB_CYCLES clocks.
module sw_debounce #(
    parameter int DB_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_db
);

    localparam int CNT_W = $clog2(DB_CYCLES) + 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    // Bring the raw level into the clk domain.
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing samples; accept the new level once the run is long enough.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/clk_cpu_ctrl.sv
// CPU clock-enable controller. Consumes the free-running clkdiv bus and the
// debounced board switches, and produces a one-clock cpu_ce, a widened
// Clk_CPU pulse, the current mode and a running step count. Mode changes
// are committed only on a tick of the destination rate, so the CPU never
// sees a shortened period.
module clk_cpu_ctrl
    import clk_cpu_pkg::*;
#(
    parameter int FAST_BIT  = 2,
    parameter int SLOW_BIT  = 24,
    parameter int DB_CYCLES = 65536,
    parameter int PW        = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      clkdiv,
    input  logic             SW2,
    input  logic             run_sw,
    input  logic             step_btn,
    output logic             cpu_ce,
    output logic             Clk_CPU,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int PW_W = FAST_BIT + 1;

    if (!pw_in_range(FAST_BIT, PW)) begin : g_pw_check
        $error("clk_cpu_ctrl: PW out of range for FAST_BIT");
    end

    logic             w_db_sw2;
    logic             w_db_run;
    logic             w_db_step;
    logic             w_unused_clkdiv;
    logic             w_tick_f;
    logic             w_tick_s;
    logic             w_tgt_tick;
    logic             w_step_rise;
    logic             w_ce_nxt;
    state_t           w_tgt;
    state_t           w_state_nxt;

    logic [1:0]       r_tap_q;
    logic             r_step_q;
    state_t           r_state;
    logic             r_cpu_ce;
    logic             r_clk_cpu;
    logic [PW_W-1:0]  r_pw_cnt;
    logic [CNT_W-1:0] r_step_cnt;

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sw2 (
        .clk(clk), .rst(rst), .i_raw(SW2), .o_db(w_db_sw2)
    );
    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk(clk), .rst(rst), .i_raw(run_sw), .o_db(w_db_run)
    );
    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk(clk), .rst(rst), .i_raw(step_btn), .o_db(w_db_step)
    );

    // Only the two taps matter; the rest of the bus is intentionally ignored.
    assign w_unused_clkdiv = ^clkdiv;

    // Rising edges of the selected taps mark the tick boundaries.
    assign w_tick_f    = clkdiv[FAST_BIT] & ~r_tap_q[0];
    assign w_tick_s    = clkdiv[SLOW_BIT] & ~r_tap_q[1];
    assign w_step_rise = w_db_step & ~r_step_q;
    assign w_tgt       = w_db_sw2 ? ST_SLOW : ST_FAST;
    assign w_tgt_tick  = w_db_sw2 ? w_tick_s : w_tick_f;

    // Delay the taps and the debounced step level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tap_q  <= 2'b00;
            r_step_q <= 1'b0;
        end else begin
            r_tap_q  <= {clkdiv[SLOW_BIT], clkdiv[FAST_BIT]};
            r_step_q <= w_db_step;
        end
    end

    // Next-state and next-enable decode; a falling run always wins over a tick.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_ce_nxt    = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (w_db_run) w_state_nxt = ST_SWITCH;
                else          w_ce_nxt    = w_step_rise;
            end
            ST_FAST: begin
                if (!w_db_run) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_ce_nxt = w_tick_f;
                    if (w_db_sw2) w_state_nxt = ST_SWITCH;
                end
            end
            ST_SLOW: begin
                if (!w_db_run) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_ce_nxt = w_tick_s;
                    if (!w_db_sw2) w_state_nxt = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (!w_db_run) begin
                    w_state_nxt = ST_HALT;
                end else if (w_tgt_tick) begin
                    w_state_nxt = w_tgt;
                    w_ce_nxt    = 1'b1;
                end
            end
            default: w_state_nxt = ST_HALT;
        endcase
    end

    // State register and registered enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_HALT;
            r_cpu_ce <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cpu_ce <= w_ce_nxt;
        end
    end

    // Stretch each enable into a PW-cycle Clk_CPU pulse; a new enable reloads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pw_cnt  <= '0;
            r_clk_cpu <= 1'b0;
        end else if (r_cpu_ce) begin
            r_pw_cnt  <= PW_W'(PW - 1);
            r_clk_cpu <= 1'b1;
        end else if (r_pw_cnt != '0) begin
            r_pw_cnt  <= r_pw_cnt - 1'b1;
            r_clk_cpu <= 1'b1;
        end else begin
            r_clk_cpu <= 1'b0;
        end
    end

    // Count issued enables, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_step_cnt <= '0;
        else if (r_cpu_ce) r_step_cnt <= r_step_cnt + 1'b1;
    end

    assign cpu_ce   = r_cpu_ce;
    assign Clk_CPU  = r_clk_cpu;
    assign mode     = r_state;
    assign step_cnt = r_step_cnt;

endmodule

// File: tb/tb_clk_cpu_ctrl.sv
// Self-checking bench for clk_cpu_ctrl: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model.
module tb_clk_cpu_ctrl;

    localparam int FAST_BIT = 2;
    localparam int SLOW_BIT = 5;
    localparam int DB       = 4;
    localparam int PW       = 2;
    localparam int CW       = 8;

    localparam int M_HALT = 0;
    localparam int M_FAST = 1;
    localparam int M_SLOW = 2;
    localparam int M_SW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   clkdiv;
    logic          SW2, run_sw, step_btn;
    logic          cpu_ce, Clk_CPU;
    logic [1:0]    mode;
    logic [CW-1:0] step_cnt;

    always #5 clk = ~clk;

    clk_cpu_ctrl #(
        .FAST_BIT(FAST_BIT), .SLOW_BIT(SLOW_BIT), .DB_CYCLES(DB),
        .PW(PW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .clkdiv(clkdiv), .SW2(SW2), .run_sw(run_sw),
        .step_btn(step_btn), .cpu_ce(cpu_ce), .Clk_CPU(Clk_CPU),
        .mode(mode), .step_cnt(step_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_ce    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Each input keeps a history of the levels it was sampled at; the
    // debounced level flips when the samples two-plus-DB edges deep all disagree.
    logic [7:0]  h_run, h_sw, h_step;
    logic        m_run, m_sw, m_step, m_step_last;
    int          m_mode, m_hi, m_cnt;
    logic        m_ce, m_clk;
    logic [31:0] m_prev_div;

    function automatic void deb_update(inout logic [7:0] h, inout logic db, input logic raw);
        logic flip;
        h    = {h[6:0], raw};
        flip = 1'b1;
        for (int j = 2; j <= DB + 1; j++) if (h[j] == db) flip = 1'b0;
        if (flip) db = ~db;
    endfunction

    task automatic model_reset();
        h_run = '0; h_sw = '0; h_step = '0;
        m_run = 0; m_sw = 0; m_step = 0; m_step_last = 0;
        m_mode = M_HALT; m_hi = 0; m_cnt = 0;
        m_ce = 0; m_clk = 0; m_prev_div = '0;
    endtask

    task automatic model_edge();
        logic tf, ts, rise, old_ce, nce, tgt_tick;
        int   nm, tgt;
        if (!rst) begin
            model_reset();
            return;
        end
        tf   = clkdiv[FAST_BIT] && !m_prev_div[FAST_BIT];
        ts   = clkdiv[SLOW_BIT] && !m_prev_div[SLOW_BIT];
        rise = m_step && !m_step_last;
        old_ce = m_ce;
        nce = 0;
        nm  = m_mode;
        tgt      = m_sw ? M_SLOW : M_FAST;
        tgt_tick = m_sw ? ts : tf;
        if (m_mode == M_HALT) begin
            if (m_run) nm = M_SW;
            else       nce = rise;
        end else if (!m_run) begin
            nm = M_HALT;
        end else if (m_mode == M_SW) begin
            if (tgt_tick) begin
                nm  = tgt;
                nce = 1;
            end
        end else begin
            nce = (m_mode == M_FAST) ? tf : ts;
            if (tgt != m_mode) nm = M_SW;
        end
        if (old_ce) m_hi = PW;
        m_clk = (m_hi > 0);
        if (m_hi > 0) m_hi--;
        if (old_ce) m_cnt = (m_cnt + 1) % (1 << CW);
        m_step_last = m_step;
        deb_update(h_run, m_run, run_sw);
        deb_update(h_sw, m_sw, SW2);
        deb_update(h_step, m_step, step_btn);
        m_prev_div = clkdiv;
        m_ce   = nce;
        m_mode = nm;
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge,
    // clkdiv advances afterwards so it is stable around every rising edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cpu_ce", cpu_ce, m_ce);
        check("Clk_CPU", Clk_CPU, m_clk);
        check("mode", mode, m_mode);
        check("step_cnt", step_cnt, m_cnt);
        if (cpu_ce) n_ce++;
        clkdiv = clkdiv + 1;
    endtask

    task automatic run_until_mode(input int want, input int budget, input string tag);
        int i = 0;
        while (mode !== want[1:0] && i < budget) begin
            cyc();
            i++;
        end
        check(tag, mode, want);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ce"}, cpu_ce, 0);
        check({tag, "_clk"}, Clk_CPU, 0);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_cnt"}, step_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] sc0;
        int            i;

        rst = 1'b1; SW2 = 0; run_sw = 0; step_btn = 0; clkdiv = '0;
        model_reset();
        #2 rst = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) cyc();
        rst = 1'b1;

        // Idle halted: nothing happens.
        n_ce = 0;
        repeat (30) cyc();
        check("idle_no_ce", n_ce, 0);

        // Fast run: SWITCH first, then FAST with a tick every 8 clocks.
        run_sw = 1;
        run_until_mode(M_SW, 20, "enter_switch");
        run_until_mode(M_FAST, 20, "enter_fast");
        n_ce = 0;
        repeat (80) cyc();
        check("fast_rate", n_ce, 10);

        // Fast to slow: quiet until the slow tap rises, which gives one pulse.
        SW2 = 1;
        run_until_mode(M_SW, 20, "fast_to_switch");
        n_ce = 0;
        run_until_mode(M_SLOW, 80, "enter_slow");
        check("switch_one_ce", n_ce, 1);
        n_ce = 0;
        repeat (128) cyc();
        check("slow_rate", n_ce, 2);

        // Short SW2 glitches are filtered out.
        SW2 = 0; cyc(); SW2 = 1;
        repeat (40) cyc();
        check("glitch1_mode", mode, M_SLOW);
        SW2 = 0; repeat (3) cyc(); SW2 = 1;
        n_ce = 0;
        repeat (64) cyc();
        check("glitch3_mode", mode, M_SLOW);
        check("glitch3_rate", n_ce, 1);

        // Halted single-step: short press, held press, bouncing press.
        run_sw = 0;
        run_until_mode(M_HALT, 20, "halt");
        n_ce = 0;
        sc0  = step_cnt;
        step_btn = 1; repeat (10) cyc(); step_btn = 0; repeat (10) cyc();
        step_btn = 1; repeat (50) cyc(); step_btn = 0; repeat (10) cyc();
        for (int k = 0; k < 6; k++) begin step_btn = (k % 2 == 0); cyc(); end
        step_btn = 1; repeat (10) cyc();
        for (int k = 0; k < 5; k++) begin step_btn = (k % 2 == 1); cyc(); end
        step_btn = 0; repeat (10) cyc();
        check("step_pulses", n_ce, 3);
        check("step_cnt_delta", CW'(step_cnt - sc0), 3);

        // Counter wrap at the top of its range.
        SW2 = 0; run_sw = 1;
        run_until_mode(M_FAST, 40, "refast");
        i = 0;
        while (step_cnt !== {CW{1'b1}} && i < 3000) begin cyc(); i++; end
        check("reach_max", step_cnt, {CW{1'b1}});
        i = 0;
        while (step_cnt === {CW{1'b1}} && i < 20) begin cyc(); i++; end
        check("wrap_zero", step_cnt, 0);

        // Reset in the middle of a Clk_CPU pulse clears everything at once.
        i = 0;
        while (Clk_CPU !== 1'b1 && i < 20) begin cyc(); i++; end
        check("pulse_seen", Clk_CPU, 1);
        #1 rst = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        repeat (3) cyc();
        rst = 1'b1;
        repeat (2 + DB) cyc();
        check("halt_after_reset", mode, M_HALT);

        // Randomized inputs against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(59) == 0) run_sw   = ~run_sw;
            if ($urandom_range(24) == 0) SW2      = ~SW2;
            if ($urandom_range(5)  == 0) step_btn = ~step_btn;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
